// File: rtl/vector_alu_seq_if.sv
// Bus bundle for vector_alu_seq: request operands in, registered results and status out.
// Handshake: start is sampled on a rising edge only while busy=0; done pulses for exactly one cycle
// when result/alu_flags/lane_ovf/illegal are updated, and a start raised in that done cycle is accepted.
interface vector_alu_seq_if #(
  parameter int LANES = 5,
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
);
  logic                   start;
  logic [2:0]             alu_control;
  logic [IDX_W-1:0]       index;
  logic [LANES*WIDTH-1:0] srca;
  logic [LANES*WIDTH-1:0] srcb;
  logic [LANES*WIDTH-1:0] result;
  logic [3:0]             alu_flags;
  logic [LANES-1:0]       lane_ovf;
  logic                   busy;
  logic                   done;
  logic                   illegal;
  logic                   state_dbg;

  modport master (
    output start, alu_control, index, srca, srcb,
    input  result, alu_flags, lane_ovf, busy, done, illegal, state_dbg
  );

  modport slave (
    input  start, alu_control, index, srca, srcb,
    output result, alu_flags, lane_ovf, busy, done, illegal, state_dbg
  );
endinterface

// File: rtl/vector_alu_seq.sv
// LANES x WIDTH vector ALU: single-cycle ADD/SUB/AND/OR/XOR, WIDTH-cycle shift-add MUL,
// registered results with NZCV flags of one selected lane and a per-lane multiply-overflow mask.
module vector_alu_seq #(
  parameter int LANES = 5,
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input logic              clk,
  input logic              reset,
  vector_alu_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b110;

  logic [0:0]             state_q;
  logic [CNT_W-1:0]       count_q;
  logic [IDX_W-1:0]       index_q;
  logic [2*WIDTH-1:0]     mcand_q  [LANES];
  logic [WIDTH-1:0]       mplier_q [LANES];
  logic [2*WIDTH-1:0]     acc_q    [LANES];
  logic [LANES*WIDTH-1:0] result_q;
  logic [3:0]             flags_q;
  logic [LANES-1:0]       ovf_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   illegal_q;

  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [WIDTH:0]         sum;
  logic [LANES-1:0]       alu_c;
  logic [LANES-1:0]       alu_v;
  logic [LANES*WIDTH-1:0] alu_flat;
  logic [LANES*WIDTH-1:0] mul_flat;
  logic [LANES-1:0]       mul_ovf;
  logic [2*WIDTH-1:0]     acc_nxt [LANES];
  logic                   op_illegal;
  logic [3:0]             alu_fl;
  logic [3:0]             mul_fl;

  always_comb begin
    op_illegal = (bus.alu_control == 3'b101) || (bus.alu_control == 3'b111);
    op_a       = '0;
    op_b       = '0;
    sum        = '0;
    alu_c      = '0;
    alu_v      = '0;
    alu_flat   = '0;
    mul_flat   = '0;
    mul_ovf    = '0;
    acc_nxt    = '{default: '0};
    alu_fl     = '0;
    mul_fl     = '0;
    for (int i = 0; i < LANES; i++) begin
      op_a = bus.srca[i*WIDTH +: WIDTH];
      op_b = bus.srcb[i*WIDTH +: WIDTH];
      sum  = '0;
      case (bus.alu_control)
        OP_ADD: begin
          sum      = {1'b0, op_a} + {1'b0, op_b};
          alu_c[i] = sum[WIDTH];
          alu_v[i] = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
          alu_flat[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        end
        OP_SUB: begin
          // A + ~B + 1: carry-out set means no borrow
          sum      = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
          alu_c[i] = sum[WIDTH];
          alu_v[i] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
          alu_flat[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        end
        OP_AND:  alu_flat[i*WIDTH +: WIDTH] = op_a & op_b;
        OP_OR:   alu_flat[i*WIDTH +: WIDTH] = op_a | op_b;
        OP_XOR:  alu_flat[i*WIDTH +: WIDTH] = op_a ^ op_b;
        default: ;
      endcase
      acc_nxt[i] = acc_q[i] + (mplier_q[i][0] ? mcand_q[i] : '0);
      mul_flat[i*WIDTH +: WIDTH] = acc_nxt[i][WIDTH-1:0];
      mul_ovf[i] = |acc_nxt[i][2*WIDTH-1:WIDTH];
    end
    // An out-of-range index matches no lane, leaving the flags at zero
    for (int i = 0; i < LANES; i++) begin
      if (bus.index == IDX_W'(i) && !op_illegal)
        alu_fl = {alu_flat[i*WIDTH+WIDTH-1], alu_flat[i*WIDTH +: WIDTH] == '0, alu_c[i], alu_v[i]};
      if (index_q == IDX_W'(i))
        mul_fl = {mul_flat[i*WIDTH+WIDTH-1], mul_flat[i*WIDTH +: WIDTH] == '0, 1'b0, mul_ovf[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      index_q   <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      ovf_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
        acc_q[i]    <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            index_q <= bus.index;
            if (bus.alu_control == OP_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
              count_q <= '0;
              for (int i = 0; i < LANES; i++) begin
                mcand_q[i]  <= {{WIDTH{1'b0}}, bus.srca[i*WIDTH +: WIDTH]};
                mplier_q[i] <= bus.srcb[i*WIDTH +: WIDTH];
                acc_q[i]    <= '0;
              end
            end else begin
              result_q  <= alu_flat;
              flags_q   <= alu_fl;
              ovf_q     <= '0;
              illegal_q <= op_illegal;
              done_q    <= 1'b1;
            end
          end
        end
        default: begin
          // One multiplier bit per lane per cycle, LSB first
          count_q <= count_q + CNT_W'(1);
          for (int i = 0; i < LANES; i++) begin
            acc_q[i]    <= acc_nxt[i];
            mcand_q[i]  <= mcand_q[i] << 1;
            mplier_q[i] <= mplier_q[i] >> 1;
          end
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= mul_flat;
            flags_q   <= mul_fl;
            ovf_q     <= mul_ovf;
            illegal_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.alu_flags = flags_q;
  assign bus.lane_ovf  = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.state_dbg = state_q;
endmodule
